multi_adder: RTL and testbench

- Parametrised N-operand adder/subtractor with per-operand input-enable handshake and a registered, flagged result.
- Collects NOPS operands in any order, over any number of cycles.
- Registers the sum or difference with an out-of-range flag, then holds OE until every producer drops its enable.
- Sits between datapath producers and consumers (e.g. the fibo sequencer) as the general successor to the two-operand adder.

---
 rtl/multi_adder.sv | 117 +++++++++++
 tb/tb_multi_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multi_adder.sv
// N-operand adder/subtractor: collects NOPS operands via per-operand enables, then
// registers a flagged result. Define MULTI_ADDER_SAT_EN to clamp out-of-range results.
module multi_adder #(
   parameter int BITS = 32,
   parameter int NOPS = 2
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [NOPS*BITS-1:0] D,
   input  logic [NOPS-1:0]      IE,
   input  logic                 SUB,
   output logic [BITS-1:0]      Y,
   output logic                 CO,
   output logic                 OE
);

   // Wide enough for NOPS full-scale operands plus a sign bit, so the math is exact.
   localparam int W = BITS + $clog2(NOPS) + 1;

   typedef enum logic [1:0] {IDLE, COLLECT, SUM, DONE} state_t;

   state_t                      state_q, state_d;
   logic [NOPS-1:0]             cap_q, cap_d;
   logic [NOPS-1:0][BITS-1:0]   ops_q, ops_d;
   logic                        sub_q, sub_d;
   logic [BITS-1:0]             y_q, y_d;
   logic                        co_q, co_d;
   logic                        oe_q, oe_d;

   logic signed [W-1:0]         acc;
   logic                        above, below;
   logic [BITS-1:0]             res;

   always_comb begin
      acc = $signed({{(W-BITS){1'b0}}, ops_q[0]});
      for (int i = 1; i < NOPS; i++) begin
         if (sub_q) acc = acc - $signed({{(W-BITS){1'b0}}, ops_q[i]});
         else       acc = acc + $signed({{(W-BITS){1'b0}}, ops_q[i]});
      end
      below = acc[W-1];
      above = ~acc[W-1] & (|acc[W-2:BITS]);
`ifdef MULTI_ADDER_SAT_EN
      if (above)      res = {BITS{1'b1}};
      else if (below) res = '0;
      else            res = acc[BITS-1:0];
`else
      res = acc[BITS-1:0];
`endif
   end

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      ops_d   = ops_q;
      sub_d   = sub_q;
      y_d     = y_q;
      co_d    = co_q;
      oe_d    = oe_q;
      case (state_q)
         IDLE, COLLECT: begin
            // First capture wins; repeat enables on a captured slot are ignored.
            for (int i = 0; i < NOPS; i++) begin
               if (IE[i] && !cap_q[i]) begin
                  cap_d[i] = 1'b1;
                  ops_d[i] = D[i*BITS +: BITS];
               end
            end
            if (&cap_d) begin
               sub_d   = SUB;
               state_d = SUM;
            end else if (|cap_d) begin
               state_d = COLLECT;
            end
         end
         SUM: begin
            y_d     = res;
            co_d    = above | below;
            oe_d    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (IE == '0) begin
               oe_d    = 1'b0;
               cap_d   = '0;
               ops_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cap_q   <= '0;
         ops_q   <= '0;
         sub_q   <= 1'b0;
         y_q     <= '0;
         co_q    <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         ops_q   <= ops_d;
         sub_q   <= sub_d;
         y_q     <= y_d;
         co_q    <= co_d;
         oe_q    <= oe_d;
      end
   end

   assign Y  = y_q;
   assign CO = co_q;
   assign OE = oe_q;

endmodule

// File: tb/tb_multi_adder.sv
// Scoreboard bench for multi_adder at BITS=8, NOPS=3; expected results come from an
// integer model and are compared when OE rises.
module tb_multi_adder;
   localparam int BITS = 8;
   localparam int NOPS = 3;

   logic                 CLK = 1'b0;
   logic                 RST_N = 1'b0;
   logic [NOPS*BITS-1:0] D = '0;
   logic [NOPS-1:0]      IE = '0;
   logic                 SUB = 1'b0;
   logic [BITS-1:0]      Y;
   logic                 CO;
   logic                 OE;

   int total = 0;
   int bad   = 0;
   logic [BITS:0] sb_q[$];
   logic oe_prev = 1'b0;

   multi_adder #(.BITS(BITS), .NOPS(NOPS)) dut (
      .CLK(CLK), .RST_N(RST_N), .D(D), .IE(IE), .SUB(SUB),
      .Y(Y), .CO(CO), .OE(OE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Exact-integer reference: returns {co, y}.
   function automatic logic [BITS:0] model(input int a, input int b, input int c, input bit sub);
      int s;
      logic co;
      logic [BITS-1:0] y;
      s  = sub ? a - b - c : a + b + c;
      co = (s < 0) || (s > 255);
`ifdef MULTI_ADDER_SAT_EN
      y = (s > 255) ? 8'hFF : (s < 0) ? 8'h00 : s[7:0];
`else
      y = s[7:0];
`endif
      return {co, y};
   endfunction

   always @(posedge CLK) begin
      #2;
      if (OE && !oe_prev) begin
         chk("sb_nonempty", (sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            logic [BITS:0] e;
            e = sb_q.pop_front();
            chk("sb_y", Y, e[BITS-1:0]);
            chk("sb_co", CO, e[BITS]);
         end
      end
      oe_prev = OE;
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_d(input int a, input int b, input int c);
      D = {c[7:0], b[7:0], a[7:0]};
   endtask

   // All operands at once; checks latency, the spec's literal result, and release.
   task automatic run3(input string tag, input int a, input int b, input int c,
                       input bit sub, input int ey, input int eco);
      set_d(a, b, c);
      SUB = sub;
      IE  = 3'b111;
      sb_q.push_back(model(a, b, c, sub));
      cyc();
      chk({tag, "_oe_sum"}, OE, 0);
      IE  = 3'b000;
      SUB = ~sub;
      cyc();
      chk({tag, "_oe"}, OE, 1);
      chk({tag, "_y"}, Y, ey);
      chk({tag, "_co"}, CO, eco);
      cyc();
      chk({tag, "_oe_rel"}, OE, 0);
      chk({tag, "_y_hold"}, Y, ey);
   endtask

   initial begin
      repeat (2) cyc();
      chk("rst_y", Y, 0);
      chk("rst_co", CO, 0);
      chk("rst_oe", OE, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      cyc();

      run3("simul", 10, 20, 30, 0, 60, 0);

      // Staggered, repeat enable ignored, SUB only sampled at completion.
      IE = 3'b010; set_d(0, 5, 0); SUB = 1'b1; cyc();
      IE = 3'b010; set_d(0, 99, 0); cyc();
      IE = 3'b001; set_d(7, 99, 0); cyc();
      IE = 3'b000; cyc();
      chk("stag_oe_wait", OE, 0);
      IE = 3'b100; set_d(0, 0, 9); SUB = 1'b0;
      sb_q.push_back(model(7, 5, 9, 0));
      cyc();
      chk("stag_oe_sum", OE, 0);
      IE = 3'b000; SUB = 1'b1; cyc();
      chk("stag_oe", OE, 1);
      chk("stag_y", Y, 21);
      chk("stag_co", CO, 0);
      cyc();
      chk("stag_rel", OE, 0);

`ifdef MULTI_ADDER_SAT_EN
      run3("addov", 200, 100, 50, 0, 255, 1);
      run3("sub_ok", 100, 20, 30, 1, 50, 0);
      run3("sub_neg", 50, 20, 40, 1, 0, 1);
`else
      run3("addov", 200, 100, 50, 0, 94, 1);
      run3("sub_ok", 100, 20, 30, 1, 50, 0);
      run3("sub_neg", 50, 20, 40, 1, 246, 1);
`endif
      run3("maxadd", 255, 255, 255, 0, 
`ifdef MULTI_ADDER_SAT_EN
           255,
`else
           253,
`endif
           1);

      // Async reset mid-collection drops the partial capture.
      IE = 3'b001; set_d(77, 0, 0); cyc();
      IE = 3'b000;
      #2 RST_N = 1'b0;
      #1;
      chk("mrst_oe", OE, 0);
      chk("mrst_y", Y, 0);
      chk("mrst_co", CO, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      cyc();
      run3("post_rst", 1, 2, 3, 0, 6, 0);

      // Enables held in DONE keep the result parked.
      set_d(1, 1, 1); SUB = 1'b0; IE = 3'b111;
      sb_q.push_back(model(1, 1, 1, 0));
      cyc(); cyc();
      chk("hold_oe_rise", OE, 1);
      for (int i = 0; i < 5; i++) begin
         set_d(50 + i, 50, 50);
         cyc();
         chk("hold_oe", OE, 1);
         chk("hold_y", Y, 3);
      end
      IE = 3'b000; cyc();
      chk("hold_rel", OE, 0);
      run3("fresh", 4, 5, 6, 0, 15, 0);

      repeat (3) cyc();
      chk("sb_drain", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
